// File: rtl/uart_cmd_decoder.sv
// Host command frame decoder: sync / address / DATA_BYTES data / [checksum] -> one register-write strobe.
// Define UART_CMD_CHECKSUM_EN to add the trailing XOR checksum byte and the frame_err check.
module uart_cmd_decoder #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_BYTES     = 4,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TIMEOUT_WIDTH  = 17
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_word,
    input  logic                    rx_done,
    output logic [5:0]              rx_bits,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    frame_err,
    output logic                    timeout_err,
    output logic                    busy
);
    localparam int unsigned              DW       = 8 * DATA_BYTES;
    localparam logic [2:0]               LAST_IDX = 3'(DATA_BYTES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
`ifdef UART_CMD_CHECKSUM_EN
        DATA,
        CSUM
`else
        DATA
`endif
    } state_t;

    state_t                   state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]               idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]    shadow_addr_q, shadow_addr_d;
    logic [DW-1:0]            shadow_data_q, shadow_data_d;
    logic                     commit_d, tout_d;
    logic                     wr_en_q, timeout_err_q, busy_q;
    logic [ADDR_WIDTH-1:0]    wr_addr_q;
    logic [DW-1:0]            wr_data_q;
    logic                     load_data;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]               csum_q, csum_d;
    logic                     ferr_d, frame_err_q;
`endif

    assign load_data = rx_done && (state_q == DATA);

    // Each lane only accepts the byte whose index matches it (little-endian assembly).
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
        assign shadow_data_d[8*gi +: 8] = (load_data && (idx_q == 3'(gi))) ? rx_word
                                                                          : shadow_data_q[8*gi +: 8];
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shadow_addr_d = shadow_addr_q;
        commit_d      = 1'b0;
        tout_d        = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
        csum_d        = csum_q;
        ferr_d        = 1'b0;
`endif
        // A byte arriving on the expiry cycle wins over the timeout.
        if (state_q != IDLE) begin
            if (rx_done) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                tout_d  = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
            end
        end
        if (rx_done) begin
            case (state_q)
                IDLE: begin
                    if (rx_word == SYNC_BYTE) state_d = ADDR;
                end
                ADDR: begin
                    shadow_addr_d = rx_word[ADDR_WIDTH-1:0];
                    idx_d         = '0;
                    state_d       = DATA;
`ifdef UART_CMD_CHECKSUM_EN
                    csum_d        = rx_word;
`endif
                end
                DATA: begin
                    idx_d = idx_q + 3'd1;
`ifdef UART_CMD_CHECKSUM_EN
                    csum_d = csum_q ^ rx_word;
                    if (idx_q == LAST_IDX) state_d = CSUM;
`else
                    if (idx_q == LAST_IDX) begin
                        state_d  = IDLE;
                        commit_d = 1'b1;
                    end
`endif
                end
`ifdef UART_CMD_CHECKSUM_EN
                CSUM: begin
                    state_d = IDLE;
                    if (rx_word == csum_q) commit_d = 1'b1;
                    else                   ferr_d   = 1'b1;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_addr_q <= '0;
            shadow_data_q <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q        <= '0;
            frame_err_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_addr_q <= shadow_addr_d;
            shadow_data_q <= shadow_data_d;
            wr_en_q       <= commit_d;
            timeout_err_q <= tout_d;
            busy_q        <= (state_d != IDLE);
            // Without a checksum the commit happens on the last data byte, so use the next-state shadow.
            if (commit_d) begin
                wr_addr_q <= shadow_addr_d;
                wr_data_q <= shadow_data_d;
            end
`ifdef UART_CMD_CHECKSUM_EN
            csum_q        <= csum_d;
            frame_err_q   <= ferr_d;
`endif
        end
    end

    assign rx_bits     = 6'd8;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;
`ifdef UART_CMD_CHECKSUM_EN
    assign frame_err   = frame_err_q;
`else
    assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomised frame-level bench for uart_cmd_decoder; expectations come from frame contents, not decoder state.
// Works with or without UART_CMD_CHECKSUM_EN defined.
module tb_uart_cmd_decoder;
    localparam int         AW   = 8;
    localparam int         DB   = 4;
    localparam int         TO   = 16;
    localparam int         TW   = 5;
    localparam int         DW   = 8 * DB;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_word = 8'h00;
    logic          rx_done = 1'b0;
    logic [5:0]    rx_bits;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_err;
    logic          timeout_err;
    logic          busy;

    uart_cmd_decoder #(
        .ADDR_WIDTH    (AW),
        .DATA_BYTES    (DB),
        .SYNC_BYTE     (SYNC),
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_word    (rx_word),
        .rx_done    (rx_done),
        .rx_bits    (rx_bits),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_err  (frame_err),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr = 0, n_ferr = 0, n_tout = 0;
    int exp_wr = 0, exp_ferr = 0, exp_tout = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_data = '0;

    always @(negedge clk) begin
        if (wr_en)       n_wr++;
        if (frame_err)   n_ferr++;
        if (timeout_err) n_tout++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick_gap(input int maxgap);
        if (maxgap < 0) return TO - 1;
        return $urandom_range(maxgap, 0);
    endfunction

    // Strobes one byte after `gap` idle cycles; returns on the sampling edge of the following cycle.
    task automatic drive_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        rx_word = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_word = 8'($urandom);
    endtask

    // maxgap < 0 spaces every byte after sync exactly at the timeout boundary.
    task automatic run_frame(input logic [7:0] addr, input logic [DW-1:0] data,
                             input logic [7:0] bad_mask, input int maxgap);
        logic [7:0] cs;
        logic [7:0] b;
        bit         good;
        cs   = addr;
        good = 1'b1;
        drive_byte(SYNC, (maxgap < 0) ? 0 : pick_gap(maxgap));
        check_eq("busy_after_sync", busy, 1);
        drive_byte(addr, pick_gap(maxgap));
        check_eq("busy_after_addr", busy, 1);
        for (int i = 0; i < DB; i++) begin
            b  = data[8*i +: 8];
            cs = cs ^ b;
            drive_byte(b, pick_gap(maxgap));
            if (i < DB - 1) check_eq("busy_mid_data", busy, 1);
        end
`ifdef UART_CMD_CHECKSUM_EN
        check_eq("busy_before_csum", busy, 1);
        good = (bad_mask == 8'h00);
        drive_byte(cs ^ bad_mask, pick_gap(maxgap));
`endif
        if (good) begin
            exp_addr = addr[AW-1:0];
            exp_data = data;
            exp_wr++;
        end else begin
            exp_ferr++;
        end
        check_eq("wr_en", wr_en, good);
        check_eq("frame_err", frame_err, !good);
        check_eq("wr_addr", wr_addr, exp_addr);
        check_eq("wr_data", wr_data, exp_data);
        check_eq("busy_end", busy, 0);
        check_eq("rx_bits", rx_bits, 8);
        $display("[TB] frame addr=%02h data=%08h good=%0d maxgap=%0d", addr, data, good, maxgap);
    endtask

    task automatic run_timeout(input int nb, input logic [63:0] pl);
        int   hit;
        logic busy_hit;
        drive_byte(SYNC, 0);
        for (int i = 0; i < nb; i++) drive_byte(pl[8*i +: 8], $urandom_range(2, 0));
        hit      = 0;
        busy_hit = 1'b1;
        for (int s = 1; s <= 3 * TO; s++) begin
            if (timeout_err) begin
                hit      = s;
                busy_hit = busy;
                break;
            end
            @(negedge clk);
        end
        exp_tout++;
        check_eq("timeout_latency", hit, TO + 1);
        check_eq("busy_after_timeout", busy_hit, 0);
        @(negedge clk);
        check_eq("timeout_single", timeout_err, 0);
        check_eq("timeout_no_write", wr_en, 0);
        $display("[TB] timeout after %0d bytes past sync, latency=%0d", nb, hit);
    endtask

    task automatic run_garbage(input int n);
        logic [7:0] g;
        for (int i = 0; i < n; i++) begin
            g = 8'($urandom);
            if (g == SYNC) g = ~SYNC;
            drive_byte(g, $urandom_range(2, 0));
            check_eq("busy_garbage", busy, 0);
        end
        $display("[TB] garbage %0d bytes", n);
    endtask

    task automatic run_reset(input int nb);
        drive_byte(SYNC, 0);
        for (int i = 0; i < nb; i++) drive_byte(8'($urandom), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_timeout_err", timeout_err, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_rx_bits", rx_bits, 8);
        rst_n    = 1'b1;
        exp_addr = '0;
        exp_data = '0;
        $display("[TB] reset after %0d bytes past sync", nb);
    endtask

    initial begin
        logic [23:0] garbage;
        int          kind;

        repeat (3) @(negedge clk);
        check_eq("reset_wr_en", wr_en, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_wr_addr", wr_addr, 0);
        check_eq("reset_wr_data", wr_data, 0);
        check_eq("reset_frame_err", frame_err, 0);
        check_eq("reset_timeout_err", timeout_err, 0);
        check_eq("reset_rx_bits", rx_bits, 8);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(8'h10, 32'hDEADBEEF, 8'h00, 0);
        @(negedge clk);
        check_eq("wr_en_single", wr_en, 0);

        run_frame(8'h10, 32'h12345678, 8'h01, 0);

        garbage = 24'h5AFF00;
        for (int i = 0; i < 3; i++) begin
            drive_byte(garbage[8*i +: 8], 0);
            check_eq("busy_garbage_fixed", busy, 0);
        end
        run_frame(8'h10, 32'hDEADBEEF, 8'h00, 0);

        run_timeout(2, 64'hEF10);
        run_frame(8'h10, 32'hDEADBEEF, 8'h00, 1);

        run_reset(1);
        run_frame(8'h10, 32'hDEADBEEF, 8'h00, 0);

        run_frame(8'h22, 32'h04030201, 8'h00, 0);
        run_frame(8'h5C, 32'hA5A5A5A5, 8'h00, -1);

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(5, 0);
            case (kind)
                0, 1: run_frame(8'($urandom), DW'($urandom), 8'h00, 3);
                2:    run_frame(8'($urandom), DW'($urandom), 8'($urandom_range(255, 1)), 3);
                3: begin
                    run_garbage($urandom_range(4, 1));
                    run_frame(8'($urandom), DW'($urandom), 8'h00, 2);
                end
                4:    run_timeout($urandom_range(DB, 0), {$urandom(), $urandom()});
                default: run_reset($urandom_range(DB, 0));
            endcase
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check_eq("total_writes", n_wr, exp_wr);
        check_eq("total_frame_errs", n_ferr, exp_ferr);
        check_eq("total_timeouts", n_tout, exp_tout);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
